// File: rtl/serial_lut_adder_pkg.sv
// serial_lut_adder_pkg: shared states, LUT3 init patterns and parameter check
package serial_lut_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [7:0] SUM_INIT = 8'h96;
    localparam logic [7:0] CARRY_INIT = 8'hE8;
    function automatic bit width_digit_ok(int w, int d);
        return w >= 2 && d >= 1 && w % d == 0;
    endfunction
endpackage

// File: rtl/serial_lut_adder_lut_full_adder.sv
// lut_full_adder: one-bit full adder built from two 3-input lookup tables
module lut_full_adder
    import serial_lut_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s = SUM_INIT[{a, b, cin}];
    assign cout = CARRY_INIT[{a, b, cin}];
endmodule

// File: rtl/serial_lut_adder.sv
// serial_lut_adder: digit-serial add/subtract through a LUT full-adder chain behind start/ready
module serial_lut_adder
    import serial_lut_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    if (!width_digit_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_lut_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
    state_t state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, sum_sh, sum_nx;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0] c;
    logic [CW-1:0] cnt;
    logic carry, accept, last;
    assign c[0] = carry;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        lut_full_adder u_fa (
            .a(op_a[i]),
            .b(op_b[i]),
            .cin(c[i]),
            .s(dsum[i]),
            .cout(c[i+1])
        );
    end
    always_comb begin
        READY = state != RUN;
        DONE = state == FIN;
        accept = START && READY;
        last = state == RUN && cnt == CW'(N - 1);
        state_nx = accept ? RUN : last ? FIN : state == FIN ? IDLE : state;
        sum_nx = (sum_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end
    // the top cell of the final digit sees the carry into the MSB, hence OVF from c[DIGIT-1]
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a <= '0;
            op_b <= '0;
            sum_sh <= '0;
            carry <= 1'b0;
            cnt <= '0;
            S <= '0;
            COUT <= 1'b0;
            OVF <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_a <= A;
                op_b <= SUB ? ~B : B;
                carry <= CIN ^ SUB;
                cnt <= '0;
            end else if (state == RUN) begin
                op_a <= op_a >> DIGIT;
                op_b <= op_b >> DIGIT;
                sum_sh <= sum_nx;
                carry <= c[DIGIT];
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                S <= sum_nx;
                COUT <= c[DIGIT];
                OVF <= c[DIGIT-1] ^ c[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_serial_lut_adder.sv
// tb_serial_lut_adder: vector table, random and protocol checks over three parameterisations
module tb_serial_lut_adder;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic start = 0, sub = 0, cin = 0, ready, done, cout, ovf;
    logic [7:0] a = 0, b = 0, s;
    logic start4 = 0, sub4 = 0, cin4 = 0, ready4, done4, cout4, ovf4;
    logic [7:0] a4 = 0, b4 = 0, s4;
    logic start3 = 0, sub3 = 0, cin3 = 0, ready3, done3, cout3, ovf3;
    logic [2:0] a3 = 0, b3 = 0, s3;

    serial_lut_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .START(start), .SUB(sub), .A(a), .B(b), .CIN(cin),
        .READY(ready), .DONE(done), .S(s), .COUT(cout), .OVF(ovf));
    serial_lut_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .START(start4), .SUB(sub4), .A(a4), .B(b4), .CIN(cin4),
        .READY(ready4), .DONE(done4), .S(s4), .COUT(cout4), .OVF(ovf4));
    serial_lut_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
        .clk(clk), .rst(rst), .START(start3), .SUB(sub3), .A(a3), .B(b3), .CIN(cin3),
        .READY(ready3), .DONE(done3), .S(s3), .COUT(cout3), .OVF(ovf3));

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic on the effective operands
    function automatic logic [9:0] model(int w, int x, int y, bit sb, bit ci);
        int mask = (1 << w) - 1;
        int bx = (sb ? ~y : y) & mask;
        int full = x + bx + int'(ci ^ sb);
        int r = full & mask;
        int m = w - 1;
        bit co = ((full >> w) & 1) == 1;
        bit ov = (((x >> m) & 1) == ((bx >> m) & 1)) && (((r >> m) & 1) != ((x >> m) & 1));
        return {ov, co, 8'(r)};
    endfunction

    task automatic op8(input logic [7:0] ta, tbv, input logic ts, tc, output int lat, output int rl);
        @(negedge clk);
        a = ta; b = tbv; sub = ts; cin = tc; start = 1;
        @(posedge clk);
        #1;
        start = 0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 0; rl = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) break;
            if (!ready) rl++;
            @(posedge clk);
            lat++;
        end
        if (lat >= 40) check("op8_timeout_done", 32'(done), 1);
    endtask

    task automatic op4(input logic [7:0] ta, tbv, input logic ts, tc, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tbv; sub4 = ts; cin4 = tc; start4 = 1;
        @(posedge clk);
        #1;
        start4 = 0; a4 = 8'($urandom); b4 = 8'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done4) break;
            @(posedge clk);
            lat++;
        end
        if (lat >= 40) check("op4_timeout_done", 32'(done4), 1);
    endtask

    task automatic op3(input logic [2:0] ta, tbv, input logic ts, tc, output int lat);
        @(negedge clk);
        a3 = ta; b3 = tbv; sub3 = ts; cin3 = tc; start3 = 1;
        @(posedge clk);
        #1;
        start3 = 0; a3 = 3'($urandom); b3 = 3'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done3) break;
            @(posedge clk);
            lat++;
        end
        if (lat >= 40) check("op3_timeout_done", 32'(done3), 1);
    endtask

    typedef struct {
        logic [7:0] va, vb;
        logic vsub, vcin;
        logic [7:0] es;
        logic ecout, eovf;
    } vec_t;

    initial begin
        vec_t vt[5];
        int lat, rl, n, dn, nd;
        int dc[4];
        logic [7:0] ds[4];
        logic [9:0] m;
        vt[0] = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0};
        vt[1] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
        vt[2] = '{8'h80, 8'h80, 0, 0, 8'h00, 1, 1};
        vt[3] = '{8'h05, 8'h07, 1, 0, 8'hFE, 0, 0};
        vt[4] = '{8'h07, 8'h05, 1, 1, 8'h01, 1, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_s", 32'(s), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            op8(vt[i].va, vt[i].vb, vt[i].vsub, vt[i].vcin, lat, rl);
            check($sformatf("vec%0d_latency", i), 32'(lat), 8);
            check($sformatf("vec%0d_ready_low", i), 32'(rl), 8);
            check($sformatf("vec%0d_s", i), 32'(s), 32'(vt[i].es));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vt[i].ecout));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].eovf));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic rs, rc;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            op8(ra, rb, rs, rc, lat, rl);
            m = model(8, int'(ra), int'(rb), rs, rc);
            check($sformatf("rand%0d_%0h_%0h_%0d_%0d", i, ra, rb, rs, rc), {22'b0, ovf, cout, s}, 32'(m));
        end

        // START during RUN is dropped
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 0; cin = 0; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignore_done_seen", 32'(done), 1);
        check("ignore_s", 32'(s), 32'h30);
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("ignore_no_extra_done", 32'(dn), 0);
        check("ignore_s_held", 32'(s), 32'h30);

        // START held across the DONE cycle: two results, nine cycles apart
        @(negedge clk);
        a = 8'h01; b = 8'h02; sub = 0; cin = 0; start = 1;
        @(posedge clk);
        #1 a = 8'h03; b = 8'h04;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && nd < 4) begin
                dc[nd] = k; ds[nd] = s; nd++;
                if (nd == 1) begin
                    @(posedge clk);
                    #1 start = 0;
                end
            end
        end
        start = 0;
        check("b2b_done_count", 32'(nd), 2);
        if (nd >= 2) begin
            check("b2b_spacing", 32'(dc[1] - dc[0]), 9);
            check("b2b_s0", 32'(ds[0]), 32'h03);
            check("b2b_s1", 32'(ds[1]), 32'h07);
        end

        // reset on the fourth RUN cycle, racing a START
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(negedge clk);
        rst = 1; start = 1;
        @(negedge clk);
        check("midrst_ready", 32'(ready), 1);
        check("midrst_done", 32'(done), 0);
        check("midrst_s", 32'(s), 0);
        check("midrst_cout", 32'(cout), 0);
        check("midrst_ovf", 32'(ovf), 0);
        rst = 0; start = 0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst_no_done", 32'(dn), 0);

        // WIDTH=8, DIGIT=4
        op4(8'h3C, 8'h5A, 0, 0, lat);
        check("d4_latency", 32'(lat), 2);
        check("d4_s", 32'(s4), 32'h96);
        check("d4_flags", {30'b0, ovf4, cout4}, 32'b10);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] ra, rb;
            logic rs, rc;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            op4(ra, rb, rs, rc, lat);
            m = model(8, int'(ra), int'(rb), rs, rc);
            check($sformatf("d4_rand%0d", i), {22'b0, ovf4, cout4, s4}, 32'(m));
        end

        // WIDTH=3, DIGIT=1 exhaustive
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int v = 0; v < 4; v++) begin
                    op3(3'(x), 3'(y), v[1], v[0], lat);
                    m = model(3, x, y, v[1], v[0]);
                    check($sformatf("w3_%0d_%0d_sub%0d_cin%0d", x, y, v[1], v[0]),
                          {22'b0, ovf3, cout3, 5'b0, s3}, 32'(m));
                    if (lat != 3) check("w3_latency", 32'(lat), 3);
                end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
